// File: rtl/oursring_req_dispatch.sv
// Request dispatcher for the oursring: steers AR/AW/W from one station to N_OUT_PORT ring outputs.
// Optional macro OURSRING_REQ_DECERR_EN drops all-zero-match requests and pulses o_decerr.
package oursring_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } oursring_req_if_ar_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
  } oursring_req_if_aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  id;
    logic        last;
  } oursring_req_if_w_t;
endpackage

module oursring_req_dispatch
  import oursring_pkg::*;
#(
  parameter int N_OUT_PORT     = 3,
  parameter int W_ROUTE_DEPTH  = 4,
  parameter int WLAST_POSITION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  oursring_req_if_ar_t      i_req_if_ar,
  input  logic                     i_req_if_arvalid,
  output logic                     i_req_if_arready,
  input  oursring_req_if_aw_t      i_req_if_aw,
  input  logic                     i_req_if_awvalid,
  output logic                     i_req_if_awready,
  input  oursring_req_if_w_t       i_req_if_w,
  input  logic                     i_req_if_wvalid,
  output logic                     i_req_if_wready,
  input  logic [N_OUT_PORT-1:0]    is_ar_dst_match,
  input  logic [N_OUT_PORT-1:0]    is_aw_dst_match,
  output oursring_req_if_ar_t      o_req_ppln_if_ar [N_OUT_PORT],
  output logic [N_OUT_PORT-1:0]    o_req_ppln_if_arvalid,
  input  logic [N_OUT_PORT-1:0]    o_req_ppln_if_arready,
  output oursring_req_if_aw_t      o_req_ppln_if_aw [N_OUT_PORT],
  output logic [N_OUT_PORT-1:0]    o_req_ppln_if_awvalid,
  input  logic [N_OUT_PORT-1:0]    o_req_ppln_if_awready,
  output oursring_req_if_w_t       o_req_ppln_if_w [N_OUT_PORT],
  output logic [N_OUT_PORT-1:0]    o_req_ppln_if_wvalid,
  input  logic [N_OUT_PORT-1:0]    o_req_ppln_if_wready,
  output logic                     o_decerr,
  output logic                     clk_en
);

  localparam int IDXW = (N_OUT_PORT > 1) ? $clog2(N_OUT_PORT) : 1;
  localparam int PTRW = $clog2(W_ROUTE_DEPTH);
  localparam int CNTW = PTRW + 1;

  // Lowest set bit wins; an empty vector falls back to the ring default exit.
  function automatic logic [IDXW-1:0] lowestIdx(input logic [N_OUT_PORT-1:0] m);
    lowestIdx = IDXW'(N_OUT_PORT - 1);
    for (int k = N_OUT_PORT - 1; k >= 0; k--) begin
      if (m[k]) lowestIdx = IDXW'(k);
    end
  endfunction

  oursring_req_if_ar_t r_ar [N_OUT_PORT];
  oursring_req_if_aw_t r_aw [N_OUT_PORT];
  oursring_req_if_w_t  r_w  [N_OUT_PORT];
  logic [N_OUT_PORT-1:0] r_ar_vld, r_aw_vld, r_w_vld;
  logic [IDXW:0]         r_fifo [W_ROUTE_DEPTH];
  logic [PTRW-1:0]       r_wptr, r_rptr;
  logic [CNTW-1:0]       r_cnt;

  logic [IDXW-1:0]       w_ar_sel, w_aw_sel, w_head_idx;
  logic [N_OUT_PORT-1:0] w_ar_can, w_aw_can, w_w_can;
  logic                  w_ar_drop, w_aw_drop, w_head_sink;
  logic                  w_ar_hs, w_aw_hs, w_w_hs, w_push, w_pop, w_empty, w_full;
  logic [IDXW:0]         w_head;

  assign w_ar_sel = lowestIdx(is_ar_dst_match);
  assign w_aw_sel = lowestIdx(is_aw_dst_match);
`ifdef OURSRING_REQ_DECERR_EN
  assign w_ar_drop = ~|is_ar_dst_match;
  assign w_aw_drop = ~|is_aw_dst_match;
`else
  assign w_ar_drop = 1'b0;
  assign w_aw_drop = 1'b0;
`endif

  assign w_ar_can = ~r_ar_vld | o_req_ppln_if_arready;
  assign w_aw_can = ~r_aw_vld | o_req_ppln_if_awready;
  assign w_w_can  = ~r_w_vld  | o_req_ppln_if_wready;

  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == CNTW'(W_ROUTE_DEPTH));
  assign w_head      = r_fifo[r_rptr];
  assign w_head_sink = w_head[IDXW];
  assign w_head_idx  = w_head[IDXW-1:0];

  assign i_req_if_arready = w_ar_drop | w_ar_can[w_ar_sel];
  assign i_req_if_awready = ~w_full & (w_aw_drop | w_aw_can[w_aw_sel]);
  assign i_req_if_wready  = ~w_empty & (w_head_sink | w_w_can[w_head_idx]);

  assign w_ar_hs = i_req_if_arvalid & i_req_if_arready;
  assign w_aw_hs = i_req_if_awvalid & i_req_if_awready;
  assign w_w_hs  = i_req_if_wvalid & i_req_if_wready;
  assign w_push  = w_aw_hs;
  assign w_pop   = w_w_hs & i_req_if_w[WLAST_POSITION];

  // Per-output one-entry stages: load on a handshake aimed here, else drain on downstream ready.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N_OUT_PORT; j++) begin
      if (rst) begin
        r_ar_vld[j] <= 1'b0;
        r_aw_vld[j] <= 1'b0;
        r_w_vld[j]  <= 1'b0;
      end else begin
        if (w_ar_hs && !w_ar_drop && w_ar_sel == IDXW'(j)) begin
          r_ar_vld[j] <= 1'b1;
          r_ar[j]     <= i_req_if_ar;
        end else if (o_req_ppln_if_arready[j]) begin
          r_ar_vld[j] <= 1'b0;
        end
        if (w_aw_hs && !w_aw_drop && w_aw_sel == IDXW'(j)) begin
          r_aw_vld[j] <= 1'b1;
          r_aw[j]     <= i_req_if_aw;
        end else if (o_req_ppln_if_awready[j]) begin
          r_aw_vld[j] <= 1'b0;
        end
        if (w_w_hs && !w_head_sink && w_head_idx == IDXW'(j)) begin
          r_w_vld[j] <= 1'b1;
          r_w[j]     <= i_req_if_w;
        end else if (o_req_ppln_if_wready[j]) begin
          r_w_vld[j] <= 1'b0;
        end
      end
    end
  end

  // AW->W route FIFO; a SINK entry (top bit) marks W beats to be swallowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {w_aw_drop, w_aw_sel};
        r_wptr         <= r_wptr + PTRW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTRW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CNTW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CNTW'(1);
    end
  end

`ifdef OURSRING_REQ_DECERR_EN
  logic r_decerr;
  always_ff @(posedge clk) begin
    if (rst) r_decerr <= 1'b0;
    else     r_decerr <= (w_ar_hs & w_ar_drop) | (w_aw_hs & w_aw_drop);
  end
  assign o_decerr = r_decerr;
`else
  assign o_decerr = 1'b0;
`endif

  assign o_req_ppln_if_ar      = r_ar;
  assign o_req_ppln_if_aw      = r_aw;
  assign o_req_ppln_if_w       = r_w;
  assign o_req_ppln_if_arvalid = r_ar_vld;
  assign o_req_ppln_if_awvalid = r_aw_vld;
  assign o_req_ppln_if_wvalid  = r_w_vld;

  assign clk_en = i_req_if_arvalid | i_req_if_awvalid | i_req_if_wvalid |
                  (|r_ar_vld) | (|r_aw_vld) | (|r_w_vld) | ~w_empty;

endmodule

// File: doc/oursring_req_dispatch.md
# oursring_req_dispatch

Request-direction dispatcher for the oursring: takes one AXI-style request stream (AR, AW, W) from a station and steers each request to one of N_OUT_PORT ring pipeline outputs, chosen by the station's destination-match vectors. It is the outbound counterpart of the response crossbar, which merges B/R responses back toward requesters. AW routing decisions are queued so W beats follow their AW to the same output until `wlast`. Per-output single-entry pipeline registers give one-cycle latency at full throughput.

## Interface
- N_OUT_PORT, 3, number of ring outputs (1..8)
- W_ROUTE_DEPTH, 4, entries in AW->W route FIFO (power of two, ≥2)
- WLAST_POSITION, 0, bit index of `wlast` inside `oursring_req_if_w_t`

- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- i_req_if_ar / i_req_if_arvalid / i_req_if_arready  in/in/out  `oursring_req_if_ar_t`/1/1  AR input
- i_req_if_aw / i_req_if_awvalid / i_req_if_awready  in/in/out  `oursring_req_if_aw_t`/1/1  AW input
- i_req_if_w / i_req_if_wvalid / i_req_if_wready  in/in/out  `oursring_req_if_w_t`/1/1  W input
- is_ar_dst_match, is_aw_dst_match  in  N_OUT_PORT each  bit j set: current AR/AW targets output j
- o_req_ppln_if_ar[j] / arvalid[j] / arready[j]  out/out/in  per-output AR
- o_req_ppln_if_aw[j] / awvalid[j] / awready[j]  out/out/in  per-output AW
- o_req_ppln_if_w[j] / wvalid[j] / wready[j]  out/out/in  per-output W
- o_decerr  out  1  one-cycle pulse per dropped AR/AW (macro only; else tied 0)
- clk_en  out  1  activity indication for upstream ICG

## Operation
- Destination select: lowest set bit of match vector wins; multiple set bits are legal, lowest index only.
- Each output/channel has a one-entry register stage; stage can accept when empty or its downstream ready is high this cycle.
- AR: `arready` = selected stage can accept. On handshake, payload loads into that stage next cycle.
- AW: `awready` = selected stage can accept AND route FIFO count < W_ROUTE_DEPTH (no same-cycle pop credit). On handshake, push destination index into route FIFO.
- W: `wready` = 0 if route FIFO empty; else = head-destination W stage can accept. On handshake with `wlast`=1, pop FIFO; non-last beats keep head.
- W never bypasses the FIFO: W arriving same cycle as its AW into empty FIFO waits ≥1 cycle.
- AR, AW, W operate independently; different outputs may be loaded in the same cycle.
- clk_en = any input valid | any stage valid | FIFO non-empty.

## Timing
- Reset: all o_*valid = 0, o_decerr = 0, FIFO empty (count 0, pointers 0); stage payloads don't-care.
- Input handshake in cycle N -> output valid in cycle N+1; held stable until output handshake.
- Full throughput: back-to-back beats to same output when downstream ready stays high.
- Ready signals are combinational from match vectors, stage state and downstream ready; valid never depends on ready.
- FIFO pointers wrap modulo W_ROUTE_DEPTH; push and pop in same cycle keep count unchanged.
- Reset asserted mid-burst: stages and FIFO cleared next edge; partial bursts discarded.

## Configuration
- OURSRING_REQ_DECERR_EN defined: AR/AW with all-zero match vector is accepted immediately (ready=1), dropped, and `o_decerr` pulses next cycle; dropped AW pushes a SINK entry, and W beats for it are accepted with `wready`=1 and discarded until `wlast` pops it.
- Not defined: all-zero match is routed to output N_OUT_PORT-1 (ring default exit); `o_decerr` tied 0; no SINK entry.

## Test plan
- AR with match 3'b010, out ready=1 -> `o_req_ppln_if_arvalid[1]`=1 one cycle later, payload equal; arvalid[0],[2] stay 0.
- AW match 3'b100 then 4-beat W (wlast on beat 4), out[2] ready -> 4 beats on W output 2, FIFO count 1->0 after beat 4.
- Five AWs with no W, W_ROUTE_DEPTH=4 -> first four accepted, fifth sees `awready`=0 until a W burst with `wlast` completes.
- Out[0] arready held 0 with stage full -> `i_req_if_arready`=0 for match 3'b001 while AR to match 3'b010 still accepted.
- Match 3'b011 -> routed to output 0 only.
- With OURSRING_REQ_DECERR_EN, AW match 0 + 2-beat W -> `o_decerr` one pulse, both W beats accepted, no output valid; without macro -> burst appears on output N_OUT_PORT-1.
